gray_to_binary_seq: RTL and testbench

Sequential Gray-to-binary decoder: the receiving end of the team's `grey_code` binary-to-Gray encoder. It accepts one WIDTH-bit Gray word through a valid/ready handshake and resolves it MSB-first, one bit per clock. It then presents the binary word through a second valid/ready handshake. It sits downstream of Gray-coded sources such as encoder outputs, Gray counters and position encoders.

---
 rtl/gray_pkg.sv | 21 ++
 rtl/gray_adj_checker.sv | 47 ++++
 rtl/gray_to_binary_seq.sv | 113 +++++++++++
 tb/tb_gray_to_binary_seq.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code types, limits and popcount helper
package gray_pkg;

    localparam int GRAY_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        DONE
    } gray_dec_state_t;

    function automatic int unsigned gray_popcount(input logic [GRAY_MAX_WIDTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < GRAY_MAX_WIDTH; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_adj_checker.sv
// rtl/gray_adj_checker.sv - sticky flag for accepted Gray words that are not one-bit neighbours
module gray_adj_checker
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             accept,
    input  logic [WIDTH-1:0] gray_in,
    output logic             step_error
);

    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic             have_prev_q, have_prev_d;
    logic             step_error_q, step_error_d;

    always_comb begin
        prev_gray_d  = prev_gray_q;
        have_prev_d  = have_prev_q;
        step_error_d = step_error_q;
        if (accept) begin
            prev_gray_d = gray_in;
            have_prev_d = 1'b1;
            // a repeated word (distance 0) counts as a violation too
            if (have_prev_q &&
                gray_popcount(GRAY_MAX_WIDTH'(prev_gray_q ^ gray_in)) != 1) begin
                step_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_gray_q  <= '0;
            have_prev_q  <= 1'b0;
            step_error_q <= 1'b0;
        end else begin
            prev_gray_q  <= prev_gray_d;
            have_prev_q  <= have_prev_d;
            step_error_q <= step_error_d;
        end
    end

    assign step_error = step_error_q;

endmodule

// File: rtl/gray_to_binary_seq.sv
// rtl/gray_to_binary_seq.sv - bit-serial MSB-first Gray-to-binary decoder; GRAY_DEC_ADJ_CHECK_EN adds step_error
module gray_to_binary_seq
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             step_error
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // the MSB of the Gray word is consumed on the acceptance edge, so only the rest is kept
    localparam int G_W   = (WIDTH > 1) ? WIDTH - 1 : 1;

    gray_dec_state_t  state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [G_W-1:0]   g_q, g_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             accept;

    assign accept = in_valid & in_ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            g_q         <= '0;
            bin_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            g_q         <= g_d;
            bin_q       <= bin_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        g_d     = g_q;
        bin_d   = bin_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    g_d               = gray_in[G_W-1:0];
                    bin_d[WIDTH-1]    = gray_in[WIDTH-1];
                    if (WIDTH == 1) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = IDX_W'(WIDTH - 2);
                        state_d = DECODE;
                    end
                end
            end
            DECODE: begin
                for (int i = 0; i < WIDTH - 1; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        bin_d[i] = bin_q[i+1] ^ g_q[i];
                    end
                end
                if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // handshake flags are registered from the next state so they never combine inputs
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bin_out   = bin_q;

`ifdef GRAY_DEC_ADJ_CHECK_EN
    gray_adj_checker #(
        .WIDTH(WIDTH)
    ) u_adj_checker (
        .clk       (clk),
        .reset     (reset),
        .accept    (accept),
        .gray_in   (gray_in),
        .step_error(step_error)
    );
`else
    assign step_error = 1'b0;
`endif

endmodule

// File: tb/tb_gray_to_binary_seq.sv
// tb/tb_gray_to_binary_seq.sv - scoreboard bench for gray_to_binary_seq (WIDTH 4 and WIDTH 1)
module tb_gray_to_binary_seq;

    localparam int W = 4;
`ifdef GRAY_DEC_ADJ_CHECK_EN
    localparam bit ADJ = 1'b1;
`else
    localparam bit ADJ = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] gray_in;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] bin_out;
    logic         step_error;

    logic         in1_valid;
    logic         in1_ready;
    logic [0:0]   g1;
    logic         out1_valid;
    logic         out1_ready;
    logic [0:0]   b1;
    logic         se1;

    always #5 clk = ~clk;

    gray_to_binary_seq #(.WIDTH(W)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .gray_in(gray_in), .out_valid(out_valid), .out_ready(out_ready),
        .bin_out(bin_out), .step_error(step_error)
    );

    gray_to_binary_seq #(.WIDTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in1_valid), .in_ready(in1_ready),
        .gray_in(g1), .out_valid(out1_valid), .out_ready(out1_ready),
        .bin_out(b1), .step_error(se1)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] bin;
        int           due;
    } exp_t;
    exp_t sb[$];

    bit           exp_step_err = 1'b0;
    bit           have_prev    = 1'b0;
    logic [W-1:0] prev_g       = '0;
    bit           rand_ready   = 1'b0;
    bit           ready_force  = 1'b1;

    always begin
        @(posedge clk);
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference: the binary value is the index whose Gray code equals g
    function automatic logic [W-1:0] decode_ref(input logic [W-1:0] g);
        for (int n = 0; n < (1 << W); n++) begin
            if (W'(n ^ (n >> 1)) == g) return W'(n);
        end
        return '0;
    endfunction

    task automatic send(input logic [W-1:0] g, input bit track, output int acc);
        int waited;
        waited = 0;
        acc    = -1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            in_valid = 1'($urandom);
            gray_in  = W'($urandom);
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        in_valid = 1'b1;
        gray_in  = g;
        acc      = cyc;
        if (track) sb.push_back('{bin: decode_ref(g), due: cyc + W});
        @(posedge clk);
        if (ADJ) begin
            if (have_prev && $countones(prev_g ^ g) != 1) exp_step_err = 1'b1;
            prev_g    = g;
            have_prev = 1'b1;
        end
        #1;
        in_valid = 1'b0;
        gray_in  = W'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset        = 1'b1;
        exp_step_err = 1'b0;
        have_prev    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    bit           prev_valid = 1'b0;
    bit           prev_taken = 1'b0;
    logic [W-1:0] held       = '0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_valid = 1'b0;
            prev_taken = 1'b0;
        end else begin
            check("ready_valid_excl", 32'(in_ready & out_valid), 32'd0);
            check("step_error", 32'(step_error), 32'(exp_step_err));
            if (prev_taken) begin
                check("post_handoff_valid", 32'(out_valid), 32'd0);
                check("post_handoff_ready", 32'(in_ready), 32'd1);
            end
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("bin_out", 32'(bin_out), 32'(e.bin));
                    check("latency", 32'(cyc), 32'(e.due));
                end
                held = bin_out;
            end else if (out_valid) begin
                check("hold_stable", 32'(bin_out), 32'(held));
            end
            prev_valid = out_valid;
            prev_taken = out_valid && out_ready;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, last_acc, n;
        reset      = 1'b1;
        in_valid   = 1'b0;
        gray_in    = '0;
        in1_valid  = 1'b0;
        g1         = '0;
        out1_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bin_out", 32'(bin_out), 32'd0);
        check("rst_step_error", 32'(step_error), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single word: 0100 -> 0111, in_ready low through DECODE and DONE
        send(4'b0100, 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy_in_ready", 32'(in_ready), 32'd0);
        end
        drain();

        // full sweep in Gray order with back-to-back throughput
        last_acc = -1;
        for (int i = 0; i < 16; i++) begin
            send(W'(i ^ (i >> 1)), 1'b1, acc);
            if (i > 0) check("accept_interval", 32'(acc - last_acc), 32'(W + 1));
            last_acc = acc;
        end
        drain();

        // backpressure: output must hold while out_ready is low
        ready_force = 1'b0;
        @(posedge clk);
        send(4'b1100, 1'b1, acc);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_bin_out", 32'(bin_out), 32'b1000);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        ready_force = 1'b1;
        drain();

        // randomized words with random consumer stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(W'($urandom), 1'b1, acc);
        end
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        drain();

        // reset during the second DECODE cycle discards the word
        send(4'b0110, 1'b0, acc);
        @(posedge clk);
        #1;
        reset        = 1'b1;
        exp_step_err = 1'b0;
        have_prev    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_bin_out", 32'(bin_out), 32'd0);
        send(4'b0001, 1'b1, acc);
        drain();

        // adjacency sequence: 0000, 0001 legal, 0111 illegal, 0110 legal
        pulse_reset();
        send(4'b0000, 1'b1, acc);
        send(4'b0001, 1'b1, acc);
        @(negedge clk);
        check("adj_legal", 32'(step_error), 32'd0);
        send(4'b0111, 1'b1, acc);
        @(negedge clk);
        check("adj_violation", 32'(step_error), 32'(ADJ));
        send(4'b0110, 1'b1, acc);
        drain();
        check("adj_sticky", 32'(step_error), 32'(ADJ));
        pulse_reset();
        @(negedge clk);
        check("adj_cleared", 32'(step_error), 32'd0);

        // WIDTH = 1: output valid the cycle right after acceptance
        for (int i = 0; i < 2; i++) begin
            n = 0;
            @(negedge clk);
            while (!in1_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            in1_valid = 1'b1;
            g1        = 1'(1 - i);
            @(posedge clk);
            #1;
            in1_valid = 1'b0;
            @(negedge clk);
            check("w1_out_valid", 32'(out1_valid), 32'd1);
            check("w1_bin_out", 32'(b1), 32'(1 - i));
            check("w1_in_ready_busy", 32'(in1_ready), 32'd0);
            @(negedge clk);
            check("w1_in_ready_back", 32'(in1_ready), 32'd1);
            check("w1_out_valid_drop", 32'(out1_valid), 32'd0);
        end
        check("w1_step_error", 32'(se1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
